fetch_unit: RTL

- IF stage of the 5-stage RV32I pipeline: PC register, instruction-memory request/response handshake and IF/ID pipeline register.
- Consumes the stall_f/stall_d/flush_d and pc_src_e/redirect signals produced by the hazard unit.
- Delivers instr_d/pc_d/pc_plus4_d to decode; inserts bubbles (NOP) when memory is slow or the stage is flushed.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit_buffer.sv | 55 +++++
 rtl/fetch_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared core definitions: datapath width, bubble encoding, reset PC and fetch FSM states.
`default_nettype none

package core_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   typedef enum logic [0:0] {
      S_REQ  = 1'b0,
      S_WAIT = 1'b1
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
`default_nettype none

interface fetch_unit_if;
   import core_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

`default_nettype wire

// File: rtl/fetch_unit_buffer.sv
// One-entry holding register that catches a fetch response while decode is stalled.
`default_nettype none

module fetch_buffer
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic            load,
   input  wire logic            clear,
   input  wire logic [31:0]     instr_in,
   input  wire logic [XLEN-1:0] pc_in,
   output logic                 valid,
   output logic [31:0]          instr,
   output logic [XLEN-1:0]      pc
);

   logic            valid_q, valid_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;

   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (clear) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         instr_d = instr_in;
         pc_d    = pc_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign valid = valid_q;
   assign instr = instr_q;
   assign pc    = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// RV32I IF stage: PC register, single-outstanding imem handshake and IF/ID pipeline register.
`default_nettype none

module fetch_unit #(
   parameter int              XLEN      = core_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = core_pkg::RESET_PC,
   parameter logic [31:0]     NOP_INSTR = core_pkg::NOP_INSTR
) (
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic            stall_f,
   input  wire logic            stall_d,
   input  wire logic            flush_d,
   input  wire logic            pc_src_e,
   input  wire logic [XLEN-1:0] pc_target_e,
   fetch_unit_if.master         imem,
   output logic [31:0]          instr_d,
   output logic [XLEN-1:0]      pc_d,
   output logic [XLEN-1:0]      pc_plus4_d,
   output logic                 valid_d,
   output logic                 fetch_busy
);
   import core_pkg::*;

   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_f_q, pc_f_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            kill_q, kill_d;
   logic [31:0]     if_instr_q, if_instr_d;
   logic [XLEN-1:0] if_pc_q, if_pc_d;
   logic [XLEN-1:0] if_pc4_q, if_pc4_d;
   logic            if_valid_q, if_valid_d;

   logic            req;
   logic            grant;
   logic            rsp_live;
   logic            buf_load;
   logic            buf_clear;
   logic            buf_valid;
   logic [31:0]     buf_instr;
   logic [XLEN-1:0] buf_pc;

   always_comb begin
      state_d    = state_q;
      pc_f_d     = pc_f_q;
      req_pc_d   = req_pc_q;
      kill_d     = kill_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      if_pc4_d   = if_pc4_q;
      if_valid_d = if_valid_q;
      req        = 1'b0;
      grant      = 1'b0;
      rsp_live   = 1'b0;
      buf_load   = 1'b0;
      buf_clear  = 1'b0;

      case (state_q)
         S_REQ: begin
            // rst gating keeps the request low while the core is held in reset
            req   = rst && !stall_f && !buf_valid && !pc_src_e;
            grant = req && imem.imem_gnt;
            if (grant) begin
               req_pc_d = pc_f_q;
               pc_f_d   = pc_f_q + PC_STEP;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem.imem_rvalid) begin
               state_d  = S_REQ;
               kill_d   = 1'b0;
               rsp_live = !kill_q && !pc_src_e;
            end
         end
         default: state_d = S_REQ;
      endcase

      // A response landing together with the redirect is dropped directly, so it must not arm kill.
      if (pc_src_e) begin
         pc_f_d    = pc_target_e & ALIGN_MASK;
         buf_clear = 1'b1;
         if ((state_q == S_WAIT && !imem.imem_rvalid) || grant) begin
            kill_d = 1'b1;
         end
      end

      if (flush_d) begin
         if_instr_d = NOP_INSTR;
         if_valid_d = 1'b0;
      end else if (stall_d) begin
         buf_load = rsp_live;
      end else if (buf_valid) begin
         if_instr_d = buf_instr;
         if_pc_d    = buf_pc;
         if_pc4_d   = buf_pc + PC_STEP;
         if_valid_d = 1'b1;
         buf_clear  = 1'b1;
      end else if (rsp_live) begin
         if_instr_d = imem.imem_rdata;
         if_pc_d    = req_pc_q;
         if_pc4_d   = req_pc_q + PC_STEP;
         if_valid_d = 1'b1;
      end else begin
         if_instr_d = NOP_INSTR;
         if_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_REQ;
         pc_f_q     <= RESET_PC;
         req_pc_q   <= '0;
         kill_q     <= 1'b0;
         if_instr_q <= NOP_INSTR;
         if_pc_q    <= '0;
         if_pc4_q   <= '0;
         if_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_f_q     <= pc_f_d;
         req_pc_q   <= req_pc_d;
         kill_q     <= kill_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
         if_pc4_q   <= if_pc4_d;
         if_valid_q <= if_valid_d;
      end
   end

   fetch_buffer #(
      .XLEN (XLEN)
   ) u_fetch_buffer (
      .clk      (clk),
      .rst      (rst),
      .load     (buf_load),
      .clear    (buf_clear),
      .instr_in (imem.imem_rdata),
      .pc_in    (req_pc_q),
      .valid    (buf_valid),
      .instr    (buf_instr),
      .pc       (buf_pc)
   );

   assign imem.imem_req  = req;
   assign imem.imem_addr = pc_f_q;
   assign instr_d        = if_instr_q;
   assign pc_d           = if_pc_q;
   assign pc_plus4_d     = if_pc4_q;
   assign valid_d        = if_valid_q;
   assign fetch_busy     = (state_q == S_WAIT);

endmodule

`default_nettype wire
